// File: rtl/multiplicative_inverse_pkg.sv
// Shared definitions for the modular inverter: state encoding and default width.
package multiplicative_inverse_pkg;

  localparam int unsigned N_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/multiplicative_inverse_mod_sub.sv
// Combinational modular subtraction y = (a - b) mod p, for a, b in [0, p-1].
module multiplicative_inverse_mod_sub
  import multiplicative_inverse_pkg::*;
#(
  parameter int unsigned n = N_DEFAULT
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] p,
  output logic [n-1:0] y
);

  logic [n:0] diff;
  logic       diff_msb_unused;

  // Wrap by adding p when the plain difference would go negative; n+1 bits avoid overflow.
  always_comb begin
    if (a >= b) begin
      diff = {1'b0, a} - {1'b0, b};
    end else begin
      diff = {1'b0, a} + {1'b0, p} - {1'b0, b};
    end
  end

  // The result is below p, so the extra bit is always zero.
  assign {diff_msb_unused, y} = diff;

endmodule

// File: rtl/multiplicative_inverse.sv
// Sequential modular inverter X = A^-1 mod p using the binary extended Euclidean
// algorithm, one step per clock, self-starting after reset release.
module multiplicative_inverse
  import multiplicative_inverse_pkg::*;
#(
  parameter int unsigned n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] A,
  output logic [n-1:0] X,
  output logic         result_ready
);

  localparam logic [n-1:0] One = n'(1);

  state_t       state_q, state_d;
  logic [n-1:0] u_q, u_d, v_q, v_d;
  logic [n-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [n-1:0] x_q, x_d;
  logic         ready_q, ready_d;

  // Halving mod p: odd values get p added first so the shift is exact.
  logic [n:0]   x1_add, x2_add;
  logic [n-1:0] x1_half, x2_half;
  logic         x1_lsb_unused, x2_lsb_unused;

  assign x1_add = {1'b0, x1_q} + (x1_q[0] ? {1'b0, p} : {(n + 1){1'b0}});
  assign x2_add = {1'b0, x2_q} + (x2_q[0] ? {1'b0, p} : {(n + 1){1'b0}});
  assign {x1_half, x1_lsb_unused} = x1_add;
  assign {x2_half, x2_lsb_unused} = x2_add;

  logic [n-1:0] x1_minus_x2, x2_minus_x1;

  multiplicative_inverse_mod_sub #(.n(n)) u_sub12 (
    .a (x1_q),
    .b (x2_q),
    .p (p),
    .y (x1_minus_x2)
  );

  multiplicative_inverse_mod_sub #(.n(n)) u_sub21 (
    .a (x2_q),
    .b (x1_q),
    .p (p),
    .y (x2_minus_x1)
  );

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      x_q     <= x_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic: sample operands in idle, then one prioritised step per clock.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    x_d     = x_q;
    ready_d = ready_q;
    unique case (state_q)
      StIdle: begin
        u_d  = A;
        v_d  = p;
        x1_d = One;
        x2_d = '0;
        if (A == '0) begin
          x_d     = '0;
          ready_d = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (u_q == One) begin
          x_d     = x1_q;
          ready_d = 1'b1;
          state_d = StDone;
        end else if (v_q == One) begin
          x_d     = x2_q;
          ready_d = 1'b1;
          state_d = StDone;
        end else if ((u_q == '0) || (v_q == '0)) begin
          // gcd(A, p) != 1: no inverse exists.
          x_d     = '0;
          ready_d = 1'b1;
          state_d = StDone;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_minus_x2;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_minus_x1;
        end
      end
      StDone: begin
        // Hold result until the next reset.
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign X            = x_q;
  assign result_ready = ready_q;

endmodule

// File: tb/tb_multiplicative_inverse.sv
// Self-checking bench for multiplicative_inverse: directed cases, abort, hold and random.
module tb_multiplicative_inverse;

  localparam int unsigned N = 16;
  localparam int MaxLat = 4 * N + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] p = '0;
  logic [N-1:0] A = '0;
  logic [N-1:0] X;
  logic         result_ready;

  int vectors = 0;
  int miscompares = 0;
  int expq[$];

  multiplicative_inverse #(.n(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .p            (p),
    .A            (A),
    .X            (X),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference inverse by the classic extended Euclidean algorithm; 0 if none exists.
  function automatic int inv_model(int a, int m);
    int t, nt, r, nr, q, tmp;
    t = 0; nt = 1; r = m; nr = a;
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (r != 1) return 0;
    if (t < 0) t += m;
    return t;
  endfunction

  // Apply one reset cycle with operands, then wait for the result and score it.
  task automatic run(input string tag, input int pp, input int aa, input int exp_x,
                     input int budget, output int got_x, output int lat);
    @(negedge clk);
    reset = 1'b1;
    p = N'(pp);
    A = N'(aa);
    expq.push_back(exp_x);
    @(negedge clk);
    reset = 1'b0;
    lat = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (result_ready) begin
        lat = c;
        break;
      end
    end
    check({tag, "_ready"}, longint'(result_ready), 1);
    got_x = int'(X);
    check({tag, "_X"}, longint'(got_x), longint'(expq.pop_front()));
  endtask

  initial begin
    int gx, lat, rp, ra, rexp;

    // Reset state.
    @(negedge clk);
    check("reset_ready", longint'(result_ready), 0);
    check("reset_X", longint'(X), 0);

    run("p23497_a345", 23497, 345, 21590, MaxLat, gx, lat);
    check("p23497_a345_lat_ok", longint'(lat >= 1 && lat <= MaxLat), 1);
    run("p7_a3", 7, 3, 5, MaxLat, gx, lat);
    run("p23497_a2", 23497, 2, 11749, MaxLat, gx, lat);
    run("p23497_a1", 23497, 1, 1, MaxLat, gx, lat);
    check("a1_lat_le2", longint'(lat >= 1 && lat <= 2), 1);
    run("p23497_am1", 23497, 23496, 23496, MaxLat, gx, lat);
    run("p23497_a0", 23497, 0, 0, MaxLat, gx, lat);
    check("a0_lat", longint'(lat), 1);

    // Abort mid-operation, then restart.
    @(negedge clk);
    reset = 1'b1;
    p = N'(23497);
    A = N'(345);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_ready", longint'(result_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", longint'(result_ready), 0);
    check("abort_X", longint'(X), 0);
    run("after_abort_p7_a3", 7, 3, 5, MaxLat, gx, lat);

    // Result holds while inputs change.
    for (int i = 0; i < 20; i++) begin
      p = N'($urandom_range(3, 65535) | 1);
      A = N'($urandom_range(1, 65535));
      @(negedge clk);
      check("hold_ready", longint'(result_ready), 1);
      check("hold_X", longint'(X), 5);
    end

    // Random coprime operands: compare with model and verify A*X mod p == 1.
    for (int i = 0; i < 12; i++) begin
      do begin
        rp = int'($urandom_range(3, 65535)) | 1;
        ra = int'($urandom_range(1, rp - 1));
        rexp = inv_model(ra, rp);
      end while (rexp == 0);
      run("rand", rp, ra, rexp, MaxLat, gx, lat);
      check("rand_product", (longint'(ra) * longint'(gx)) % longint'(rp), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
